// File: rtl/sram_req_arbiter.sv
`timescale 1ns / 1ps
// Two-master arbiter sharing one SRAM-like port between instruction fetch and
// data access. Data wins by default; a starvation counter forces an inst grant
// after STARVE_MAX consecutive data grants taken while inst was waiting.
module sram_req_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] StarveMax = STARVE_MAX[2:0];

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = inst, 1 = data
    logic [2:0] starve_q, starve_d;
    logic       grant_inst;
    logic       in_addr, in_wait, inst_sel, data_sel;

    // State, owner and starvation counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Next-state: grant selection in IDLE, then address and response phases.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        grant_inst = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inst_req || data_req) begin
                    grant_inst = inst_req && (!data_req || (starve_q == StarveMax));
                    owner_d    = ~grant_inst;
                    state_d    = StAddr;
                    // Only a data grant that bypasses a waiting fetch counts.
                    if (!grant_inst && inst_req) begin
                        starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 3'd1;
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            StAddr: begin
                if (mem_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side fields follow the owner's live inputs while in ADDR, else zero.
    always_comb begin
        in_addr      = (state_q == StAddr);
        in_wait      = (state_q == StWait);
        data_sel     = in_addr && owner_q;
        inst_sel     = in_addr && !owner_q;

        mem_req      = in_addr;
        mem_wr       = data_sel && data_wr;
        mem_wstrb    = (data_sel && data_wr) ? data_wstrb : 4'h0;
        mem_addr     = data_sel ? data_addr : (inst_sel ? inst_addr : '0);
        mem_wdata    = data_sel ? data_wdata : '0;

        inst_addr_ok = inst_sel && mem_addr_ok;
        data_addr_ok = data_sel && mem_addr_ok;
        inst_data_ok = in_wait && !owner_q && mem_data_ok;
        data_data_ok = in_wait && owner_q && mem_data_ok;
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
`timescale 1ns / 1ps
// Scoreboard bench for sram_req_arbiter: requester drivers push expected
// requests, a memory model pushes expected read data, and a negedge monitor
// predicts grants from the arbitration rules and checks every handshake.
module tb_sram_req_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]    data_wstrb = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wr;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    sram_req_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [3:0]    wstrb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    int n_tests = 0;
    int n_fail  = 0;

    req_t          inst_q[$];
    req_t          data_q[$];
    logic [DW-1:0] rdata_q[$];
    bit            grant_log[$];

    // Monitor/model state.
    int            phase = 0;
    int            starve = 0;
    int            addr_cycles = 0, last_addr_cycles = 0;
    int            wait_cycles = 0, last_wait_cycles = 0;
    bit            exp_owner = 1'b0;
    bit            win_inst;
    req_t          cur = '0;
    logic [DW-1:0] rexp, last_rdata = '0;

    // Memory model controls.
    int            aw_fix = -1, dw_fix = -1;
    bit            rdata_fix_en = 1'b0;
    logic [DW-1:0] rdata_fix = '0;
    bit            mem_manual = 1'b0;
    int            mph = 0, aw = -1, dw = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_inst_addr_ok", 64'(inst_addr_ok), 64'(0));
        chk("rst_data_addr_ok", 64'(data_addr_ok), 64'(0));
        chk("rst_inst_data_ok", 64'(inst_data_ok), 64'(0));
        chk("rst_data_data_ok", 64'(data_data_ok), 64'(0));
        chk("rst_mem_wr", 64'(mem_wr), 64'(0));
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    endtask

    // Monitor: arbitration-level model of grants plus per-cycle handshake checks.
    always @(negedge clk) begin
        if (!resetn) begin
            phase  = 0;
            starve = 0;
            check_reset_outs();
        end else begin
            case (phase)
                0: begin
                    chk("idle_mem_req", 64'(mem_req), 64'(0));
                    chk("idle_oks", 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
                        64'(0));
                    if (inst_req || data_req) begin
                        win_inst = inst_req && (!data_req || starve == int'(SMAX));
                        if (!win_inst && inst_req) starve = (starve < int'(SMAX)) ? starve + 1 : starve;
                        else starve = 0;
                        exp_owner = !win_inst;
                        grant_log.push_back(exp_owner);
                        if (win_inst) begin
                            chk("inst_pending_entry", 64'(inst_q.size()), 64'(1));
                            if (inst_q.size() > 0) cur = inst_q[0];
                        end else begin
                            chk("data_pending_entry", 64'(data_q.size()), 64'(1));
                            if (data_q.size() > 0) cur = data_q[0];
                        end
                        addr_cycles = 0;
                        phase = 1;
                    end
                end
                1: begin
                    addr_cycles++;
                    chk("addr_mem_req", 64'(mem_req), 64'(1));
                    chk("addr_mem_addr", 64'(mem_addr), 64'(cur.addr));
                    chk("addr_mem_wr", 64'(mem_wr), 64'(cur.wr));
                    chk("addr_mem_wstrb", 64'(mem_wstrb), 64'(cur.wr ? cur.wstrb : 4'h0));
                    chk("addr_mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(mem_addr_ok && !exp_owner));
                    chk("data_addr_ok", 64'(data_addr_ok), 64'(mem_addr_ok && exp_owner));
                    chk("addr_data_oks", 64'({inst_data_ok, data_data_ok}), 64'(0));
                    if (mem_addr_ok) begin
                        if (exp_owner && data_q.size() > 0) void'(data_q.pop_front());
                        if (!exp_owner && inst_q.size() > 0) void'(inst_q.pop_front());
                        last_addr_cycles = addr_cycles;
                        wait_cycles = 0;
                        phase = 2;
                    end
                end
                default: begin
                    wait_cycles++;
                    chk("wait_mem_req", 64'(mem_req), 64'(0));
                    chk("wait_addr_oks", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
                    chk("inst_data_ok", 64'(inst_data_ok), 64'(mem_data_ok && !exp_owner));
                    chk("data_data_ok", 64'(data_data_ok), 64'(mem_data_ok && exp_owner));
                    if (mem_data_ok) begin
                        chk("rdata_q_nonempty", 64'(rdata_q.size() > 0), 64'(1));
                        rexp = (rdata_q.size() > 0) ? rdata_q.pop_front() : '0;
                        last_rdata = exp_owner ? data_rdata : inst_rdata;
                        chk(exp_owner ? "data_rdata" : "inst_rdata", 64'(last_rdata), 64'(rexp));
                        last_wait_cycles = wait_cycles;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Memory model: programmable or random addr_ok / data_ok wait states.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_manual) continue;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom();
            if (!resetn) begin
                mph = 0;
                aw  = -1;
                continue;
            end
            if (mph == 0) begin
                if (mem_req) begin
                    if (aw < 0) aw = (aw_fix >= 0) ? aw_fix : int'($urandom_range(0, 3));
                    if (aw == 0) begin
                        mem_addr_ok = 1'b1;
                        aw  = -1;
                        mph = 1;
                        dw  = (dw_fix >= 0) ? dw_fix : int'($urandom_range(0, 3));
                    end else begin
                        aw--;
                    end
                end
            end else if (dw == 0) begin
                mem_data_ok = 1'b1;
                mem_rdata   = rdata_fix_en ? rdata_fix : $urandom();
                rdata_q.push_back(mem_rdata);
                mph = 0;
            end else begin
                dw--;
            end
        end
    end

    // Requester tasks: all start and end one time unit after a rising edge.
    task automatic issue_inst(input logic [AW-1:0] addr);
        req_t r;
        int   t;
        r = '0;
        r.addr = addr;
        inst_req  = 1'b1;
        inst_addr = addr;
        inst_q.push_back(r);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!inst_addr_ok && t < 300);
        if (!inst_addr_ok) chk("inst_addr_ok_timeout", 64'(inst_addr_ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic issue_data(input req_t r);
        int t;
        data_req   = 1'b1;
        data_wr    = r.wr;
        data_wstrb = r.wstrb;
        data_addr  = r.addr;
        data_wdata = r.wdata;
        data_q.push_back(r);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!data_addr_ok && t < 300);
        if (!data_addr_ok) chk("data_addr_ok_timeout", 64'(data_addr_ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_inst(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = int'($urandom_range(0, max_gap));
            if (gap > 0) begin
                inst_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            issue_inst($urandom() & 32'hFFFF_FFFC);
        end
        inst_req = 1'b0;
    endtask

    task automatic run_data(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int   gap;
            req_t r;
            gap = int'($urandom_range(0, max_gap));
            if (gap > 0) begin
                data_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            r.wr    = 1'($urandom_range(0, 1));
            r.wstrb = 4'($urandom());
            r.addr  = $urandom();
            r.wdata = $urandom();
            issue_data(r);
        end
        data_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (phase != 0 && t < 500);
        chk("idle_reached", 64'(phase), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        bit   starve_pat[8];
        starve_pat = '{1, 1, 1, 1, 0, 1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single inst read with fixed memory timing and read data.
        aw_fix = 0;
        dw_fix = 0;
        rdata_fix_en = 1'b1;
        rdata_fix = 32'h0280_0C0C;
        issue_inst(32'h1C00_0000);
        inst_req = 1'b0;
        wait_idle();
        chk("t1_owner", 64'(grant_log[$]), 64'(0));
        chk("t1_addr_cycles", 64'(last_addr_cycles), 64'(1));
        chk("t1_wait_cycles", 64'(last_wait_cycles), 64'(1));
        chk("t1_rdata", 64'(last_rdata), 64'(32'h0280_0C0C));
        rdata_fix_en = 1'b0;

        // Data write.
        r.wr = 1'b1;
        r.wstrb = 4'b0011;
        r.addr = 32'h1C00_1000;
        r.wdata = 32'hDEAD_BEEF;
        issue_data(r);
        data_req = 1'b0;
        wait_idle();
        chk("t2_owner", 64'(grant_log[$]), 64'(1));

        // Collision from reset: data first, inst on the following IDLE.
        reset_dut();
        grant_log.delete();
        aw_fix = -1;
        dw_fix = -1;
        fork
            run_inst(1, 0);
            run_data(1, 0);
        join
        wait_idle();
        chk("col_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("col_first", 64'(grant_log[0]), 64'(1));
            chk("col_second", 64'(grant_log[1]), 64'(0));
        end

        // Starvation: both requesters back to back.
        reset_dut();
        grant_log.delete();
        fork
            run_inst(2, 0);
            run_data(6, 0);
        join
        wait_idle();
        chk("starve_grants", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk($sformatf("starve_grant_%0d", i), 64'(grant_log[i]), 64'(starve_pat[i]));
        end

        // Wait states: 5 extra ADDR cycles, data_ok 3 cycles late.
        aw_fix = 5;
        dw_fix = 3;
        r.wr = 1'b0;
        r.wstrb = 4'hF;
        r.addr = 32'h1C00_2004;
        r.wdata = 32'h1234_5678;
        issue_data(r);
        data_req = 1'b0;
        wait_idle();
        chk("ws_addr_cycles", 64'(last_addr_cycles), 64'(6));
        chk("ws_wait_cycles", 64'(last_wait_cycles), 64'(4));

        // Reset during WAIT of a data read; the late response must be ignored.
        aw_fix = 0;
        dw_fix = 10;
        r.addr = 32'h1C00_3000;
        issue_data(r);
        data_req = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();
        mem_manual = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rst_late_data_ok", 64'(data_data_ok), 64'(0));
        check_reset_outs();
        @(posedge clk);
        #1;
        mem_data_ok = 1'b0;
        mem_manual = 1'b0;
        aw_fix = -1;
        dw_fix = -1;
        @(negedge clk);
        check_reset_outs();
        @(posedge clk);
        #1;

        // Randomised traffic from both requesters.
        fork
            run_inst(40, 3);
            run_data(40, 3);
        join
        wait_idle();
        chk("end_inst_q", 64'(inst_q.size()), 64'(0));
        chk("end_data_q", 64'(data_q.size()), 64'(0));
        chk("end_rdata_q", 64'(rdata_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
